// File: rtl/arb_field_rx.sv
// arb_field_rx: CAN arbitration-field receiver. Shifts in the identifier MSB first,
// captures RTR (and IDE plus extended identifier when EXT_ID_EN is defined) and
// pulses arb_complete for one cycle when the field has been received.
// Build option: define EXT_ID_EN to enable extended (29-bit) identifier frames.
module arb_field_rx #(
  parameter int unsigned ID_BASE_W = 11,
  parameter int unsigned ID_EXT_W  = 18
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          sample_point,
  input  logic                          stuff_bit_detected,
  input  logic                          rx_bit,
  input  logic                          sof_detected,
  input  logic                          frame_abort,
  output logic [ID_BASE_W+ID_EXT_W-1:0] id_out,
  output logic                          rtr_bit,
  output logic                          frame_type_out,
  output logic                          ide_out,
  output logic                          arb_busy,
  output logic                          arb_complete
);

  localparam int unsigned ID_W  = ID_BASE_W + ID_EXT_W;
  localparam int unsigned CNT_W = $clog2(ID_EXT_W + 1);
  localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(ID_BASE_W - 1);
`ifdef EXT_ID_EN
  localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(ID_EXT_W - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ID_BASE  = 3'd1,
    S_RTR_SRR  = 3'd2,
    S_COMPLETE = 3'd3
`ifdef EXT_ID_EN
    ,
    S_IDE      = 3'd4,
    S_ID_EXT   = 3'd5,
    S_RTR_EXT  = 3'd6
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rtr_q, rtr_d;
  logic              ftype_q, ftype_d;
  logic              ide_q, ide_d;
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;
  logic              valid_c;

  // A sampled bit counts only when it is not a stuff bit.
  assign valid_c = sample_point && !stuff_bit_detected;

  // State register and captured fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      cnt_q      <= '0;
      rtr_q      <= 1'b1;
      ftype_q    <= 1'b0;
      ide_q      <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rtr_q      <= rtr_d;
      ftype_q    <= ftype_d;
      ide_q      <= ide_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  // Next-state and next-output logic; abort outranks any bit activity.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rtr_d      = rtr_q;
    ftype_d    = ftype_q;
    ide_d      = ide_q;
    busy_d     = busy_q;
    complete_d = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      id_d    = '0;
      cnt_d   = '0;
      rtr_d   = 1'b1;
      ftype_d = 1'b0;
      ide_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (frame_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sof_detected) begin
            state_d = S_ID_BASE;
            id_d    = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        S_ID_BASE: begin
          if (valid_c) begin
            id_d = {id_q[ID_W-2:0], rx_bit};
            if (cnt_q == BASE_LAST) begin
              state_d = S_RTR_SRR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_RTR_SRR: begin
          if (valid_c) begin
            rtr_d   = rx_bit;
            ftype_d = rx_bit;
`ifdef EXT_ID_EN
            state_d = S_IDE;
`else
            state_d    = S_COMPLETE;
            busy_d     = 1'b0;
            complete_d = 1'b1;
`endif
          end
        end
`ifdef EXT_ID_EN
        S_IDE: begin
          if (valid_c) begin
            ide_d = rx_bit;
            if (rx_bit) begin
              state_d = S_ID_EXT;
              cnt_d   = '0;
            end else begin
              state_d    = S_COMPLETE;
              busy_d     = 1'b0;
              complete_d = 1'b1;
            end
          end
        end
        S_ID_EXT: begin
          if (valid_c) begin
            id_d = {id_q[ID_W-2:0], rx_bit};
            if (cnt_q == EXT_LAST) begin
              state_d = S_RTR_EXT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_RTR_EXT: begin
          if (valid_c) begin
            rtr_d      = rx_bit;
            ftype_d    = rx_bit;
            state_d    = S_COMPLETE;
            busy_d     = 1'b0;
            complete_d = 1'b1;
          end
        end
`endif
        S_COMPLETE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign id_out         = id_q;
  assign rtr_bit        = rtr_q;
  assign frame_type_out = ftype_q;
  assign ide_out        = ide_q;
  assign arb_busy       = busy_q;
  assign arb_complete   = complete_q;

endmodule

// File: tb/tb_arb_field_rx.sv
// tb_arb_field_rx: directed bench for arb_field_rx with a queue of expected frames
// popped whenever arb_complete is seen.
module tb_arb_field_rx;

  localparam int unsigned ID_W = 29;

  logic            clock;
  logic            reset_n;
  logic            enable;
  logic            sample_point;
  logic            stuff_bit_detected;
  logic            rx_bit;
  logic            sof_detected;
  logic            frame_abort;
  logic [ID_W-1:0] id_out;
  logic            rtr_bit;
  logic            frame_type_out;
  logic            ide_out;
  logic            arb_busy;
  logic            arb_complete;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            rtr;
    logic            ft;
    logic            ide;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_complete = 0;
  int   n_pushed = 0;
  logic prev_complete = 1'b0;

  arb_field_rx dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .enable             (enable),
    .sample_point       (sample_point),
    .stuff_bit_detected (stuff_bit_detected),
    .rx_bit             (rx_bit),
    .sof_detected       (sof_detected),
    .frame_abort        (frame_abort),
    .id_out             (id_out),
    .rtr_bit            (rtr_bit),
    .frame_type_out     (frame_type_out),
    .ide_out            (ide_out),
    .arb_busy           (arb_busy),
    .arb_complete       (arb_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest pending frame.
  always @(negedge clock) begin
    if (arb_complete === 1'b1) begin
      n_complete++;
      chk("complete_width", 32'(prev_complete), 32'd0);
      chk("complete_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("id_out", 32'(id_out), 32'(e.id));
        chk("rtr_bit", 32'(rtr_bit), 32'(e.rtr));
        chk("frame_type", 32'(frame_type_out), 32'(e.ft));
        chk("ide_out", 32'(ide_out), 32'(e.ide));
        chk("busy_at_complete", 32'(arb_busy), 32'd0);
      end
    end
    prev_complete <= arb_complete;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_id"}, 32'(id_out), 32'd0);
    chk({tag, "_rtr"}, 32'(rtr_bit), 32'd1);
    chk({tag, "_ft"}, 32'(frame_type_out), 32'd0);
    chk({tag, "_ide"}, 32'(ide_out), 32'd0);
    chk({tag, "_busy"}, 32'(arb_busy), 32'd0);
    chk({tag, "_complete"}, 32'(arb_complete), 32'd0);
  endtask

  // Called and returns at a negedge.
  task automatic pulse_sof();
    sof_detected = 1'b1;
    @(negedge clock);
    sof_detected = 1'b0;
  endtask

  // Idle cycle (stuff flag without sample point), then one sample; returns just after capture.
  task automatic send_bit(input logic b, input logic stuff);
    sample_point = 1'b0;
    stuff_bit_detected = 1'b1;
    rx_bit = ~b;
    @(negedge clock);
    sample_point = 1'b1;
    stuff_bit_detected = stuff;
    rx_bit = b;
    @(negedge clock);
    sample_point = 1'b0;
    stuff_bit_detected = 1'b0;
  endtask

  task automatic send_frame(input logic [10:0] base, input logic [17:0] ext_id,
                            input logic ext, input logic rtr, input int sof_at);
    exp_t e;
    logic bits[$];
    e.id  = ext ? {base, ext_id} : {18'd0, base};
    e.rtr = rtr;
    e.ft  = rtr;
    e.ide = ext;
    exp_q.push_back(e);
    n_pushed++;
    for (int i = 10; i >= 0; i--) bits.push_back(base[i]);
`ifdef EXT_ID_EN
    if (ext) begin
      bits.push_back(1'b1);
      bits.push_back(1'b1);
      for (int i = 17; i >= 0; i--) bits.push_back(ext_id[i]);
      bits.push_back(rtr);
    end else begin
      bits.push_back(rtr);
      bits.push_back(1'b0);
    end
`else
    bits.push_back(rtr);
`endif
    pulse_sof();
    for (int k = 0; k < bits.size() - 1; k++) begin
      if (k == sof_at) pulse_sof();
      send_bit(bits[k], 1'b0);
    end
    chk("busy_before_last", 32'(arb_busy), 32'd1);
    chk("no_early_complete", 32'(arb_complete), 32'd0);
    send_bit(bits[bits.size() - 1], 1'b0);
    chk("complete_latency", 32'(arb_complete), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    sample_point = 1'b0;
    stuff_bit_detected = 1'b0;
    rx_bit = 1'b1;
    sof_detected = 1'b0;
    frame_abort = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Base data frame, then a remote frame with a stray sof mid-ID.
    send_frame(11'h123, 18'h0, 1'b0, 1'b0, -1);
    send_frame(11'h7F0, 18'h0, 1'b0, 1'b1, 4);

    // Stuff bits after ID bits 5 and 10 must not count.
    begin
      exp_t e;
      e.id = '0; e.rtr = 1'b0; e.ft = 1'b0; e.ide = 1'b0;
      exp_q.push_back(e);
      n_pushed++;
      pulse_sof();
      for (int i = 0; i < 11; i++) begin
        send_bit(1'b0, 1'b0);
        if (i == 4 || i == 9) send_bit(1'b1, 1'b1);
      end
      chk("stuff_busy", 32'(arb_busy), 32'd1);
      chk("stuff_no_complete", 32'(arb_complete), 32'd0);
`ifdef EXT_ID_EN
      send_bit(1'b0, 1'b0);
`endif
      send_bit(1'b0, 1'b0);
      chk("stuff_complete", 32'(arb_complete), 32'd1);
      @(negedge clock);
    end

    // Abort after 6 ID bits, coinciding with a valid bit.
    begin
      int c0;
      c0 = n_complete;
      pulse_sof();
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
      chk("abort_pre_busy", 32'(arb_busy), 32'd1);
      frame_abort = 1'b1;
      sample_point = 1'b1;
      rx_bit = 1'b1;
      @(negedge clock);
      frame_abort = 1'b0;
      sample_point = 1'b0;
      chk("abort_busy", 32'(arb_busy), 32'd0);
      chk("abort_complete", 32'(arb_complete), 32'd0);
      for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
      chk("abort_stays_idle", 32'(arb_busy), 32'd0);
      sof_detected = 1'b1;
      frame_abort = 1'b1;
      @(negedge clock);
      sof_detected = 1'b0;
      frame_abort = 1'b0;
      chk("sof_abort_idle", 32'(arb_busy), 32'd0);
      chk("abort_no_pulse", 32'(n_complete), 32'(c0));
    end
    send_frame(11'h555, 18'h0, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clock);
    chk("hold_id", 32'(id_out), 32'h555);
    chk("hold_rtr", 32'(rtr_bit), 32'd0);

    // Synchronous clear via enable mid-ID.
    pulse_sof();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("en_pre_busy", 32'(arb_busy), 32'd1);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    chk_reset_vals("enable");
    send_bit(1'b1, 1'b0);
    chk("enable_idle", 32'(arb_busy), 32'd0);
    send_frame(11'h2AA, 18'h0, 1'b0, 1'b1, -1);

    // Asynchronous reset mid-cycle during ID.
    pulse_sof();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_frame(11'h001, 18'h0, 1'b0, 1'b0, -1);

`ifdef EXT_ID_EN
    send_frame(11'h1AB, 18'h23456, 1'b1, 1'b0, -1);
    send_frame(11'h0F0, 18'h0, 1'b0, 1'b1, -1);
`endif

    repeat (3) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("complete_count", 32'(n_complete), 32'(n_pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
